// File: rtl/rom_arb_pkg.sv
// Shared types, constants and the address-fault helper for the ROM fetch arbiter.
package rom_arb_pkg;

  localparam int ROM_BYTES_DEFAULT = 16384;

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // Addresses are zero-extended to 64 bits so the range compare stays unsigned at full width.
  function automatic logic addr_fault(input logic [63:0] addr, input logic [63:0] rom_bytes);
    return (addr[1:0] != 2'b00) || (addr > (rom_bytes - 64'd4));
  endfunction

endpackage

// File: rtl/rom_fetch_arbiter_if.sv
// Per-port request/response bundle between a requester (master) and the arbiter (slave).
interface rom_fetch_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // A request transfers on a cycle where req_valid && req_ready; a response transfers on a
  // cycle where resp_valid && resp_ready. Once raised, valid and its payload hold until taken.
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  logic              resp_ready;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/rom_arb_resp_slot.sv
// One-entry registered response slot: loads on grant, drains on resp_ready, may reload while draining.
module rom_arb_resp_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_err,
  input  logic [DATA_W-1:0] load_data,
  input  logic              resp_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              slot_free
);

  assign slot_free = !resp_valid || resp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else if (load) begin
      resp_valid <= 1'b1;
      resp_data  <= load_data;
      resp_err   <= load_err;
    end else if (resp_valid && resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Round-robin sharing of one combinational ROM between fetch (F) and data (D) ports.
// Optional stall counters are built when ROM_FETCH_ARBITER_PERF_EN is defined.
module rom_fetch_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ROM_BYTES = ROM_BYTES_DEFAULT,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  rom_fetch_arbiter_if.slave  f,
  rom_fetch_arbiter_if.slave  d,
  output logic [ADDR_W-1:0]   rom_address,
  input  logic [DATA_W-1:0]   rom_result,
  output logic [31:0]         perf_f_stall,
  output logic [31:0]         perf_d_stall,
  output port_e               dbg_last_grant
);

  logic              f_free, d_free;
  logic              elig_f, elig_d;
  logic              grant_f, grant_d, any_grant;
  logic              sel_fault;
  logic [ADDR_W-1:0] sel_addr, addr_q;
  logic [DATA_W-1:0] load_data;
  port_e             last_grant, last_grant_next;

  always_ff @(posedge clk) begin
    if (rst) last_grant <= PORT_D;
    else     last_grant <= last_grant_next;
  end

  // The port that did not win last time takes priority when both are eligible.
  always_comb begin
    elig_f          = !rst && f.req_valid && f_free;
    elig_d          = !rst && d.req_valid && d_free;
    grant_f         = elig_f && (!elig_d || (last_grant == PORT_D));
    grant_d         = elig_d && !grant_f;
    any_grant       = grant_f || grant_d;
    last_grant_next = last_grant;
    if (grant_f)      last_grant_next = PORT_F;
    else if (grant_d) last_grant_next = PORT_D;
    sel_addr  = grant_d ? d.req_addr : f.req_addr;
    sel_fault = addr_fault(64'(sel_addr), 64'(ROM_BYTES));
    load_data = sel_fault ? '0 : rom_result;
  end

  assign f.req_ready     = grant_f;
  assign d.req_ready     = grant_d;
  assign dbg_last_grant  = last_grant;
  assign rom_address     = any_grant ? {sel_addr[ADDR_W-1:2], 2'b00} : addr_q;

  always_ff @(posedge clk) begin
    if (rst)            addr_q <= '0;
    else if (any_grant) addr_q <= {sel_addr[ADDR_W-1:2], 2'b00};
  end

  rom_arb_resp_slot #(.DATA_W(DATA_W)) u_slot_f (
    .clk        (clk),
    .rst        (rst),
    .load       (grant_f),
    .load_err   (sel_fault),
    .load_data  (load_data),
    .resp_ready (f.resp_ready),
    .resp_valid (f.resp_valid),
    .resp_data  (f.resp_data),
    .resp_err   (f.resp_err),
    .slot_free  (f_free)
  );

  rom_arb_resp_slot #(.DATA_W(DATA_W)) u_slot_d (
    .clk        (clk),
    .rst        (rst),
    .load       (grant_d),
    .load_err   (sel_fault),
    .load_data  (load_data),
    .resp_ready (d.resp_ready),
    .resp_valid (d.resp_valid),
    .resp_data  (d.resp_data),
    .resp_err   (d.resp_err),
    .slot_free  (d_free)
  );

`ifdef ROM_FETCH_ARBITER_PERF_EN
  // A stall is a cycle with a pending request that was not accepted; counters saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_f_stall <= '0;
      perf_d_stall <= '0;
    end else begin
      if (f.req_valid && !grant_f && (perf_f_stall != 32'hffff_ffff))
        perf_f_stall <= perf_f_stall + 32'd1;
      if (d.req_valid && !grant_d && (perf_d_stall != 32'hffff_ffff))
        perf_d_stall <= perf_d_stall + 32'd1;
    end
  end
`else
  assign perf_f_stall = '0;
  assign perf_d_stall = '0;
`endif

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed bench for rom_fetch_arbiter: cycle-table driver, per-port expected queues, negedge monitor.
module tb_rom_fetch_arbiter;
  import rom_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rom_address;
  logic [31:0] rom_result;
  logic [31:0] perf_f_stall, perf_d_stall;
  port_e       dbg_last_grant;

  int checks   = 0;
  int failures = 0;

  logic [32:0] f_exp_q[$];
  logic [32:0] d_exp_q[$];

  rom_fetch_arbiter_if #(.ADDR_W(32), .DATA_W(32)) f_if ();
  rom_fetch_arbiter_if #(.ADDR_W(32), .DATA_W(32)) d_if ();

  rom_fetch_arbiter #(.ROM_BYTES(16384), .ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .f              (f_if.slave),
    .d              (d_if.slave),
    .rom_address    (rom_address),
    .rom_result     (rom_result),
    .perf_f_stall   (perf_f_stall),
    .perf_d_stall   (perf_d_stall),
    .dbg_last_grant (dbg_last_grant)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- ROM model ----------------
  function automatic logic [31:0] rom_model(input logic [31:0] a);
    case (a)
      32'h0000_0000, 32'h0000_0008: return 32'h2011_0001;
      32'h0000_0004:                return 32'h0800_0c05;
      32'h0000_0368:                return 32'h03e0_0008;
      default:                      return 32'hdead_beef;
    endcase
  endfunction

  assign rom_result = rom_model(rom_address);

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (f_if.resp_valid && f_if.resp_ready) begin
        if (f_exp_q.size() == 0) check("f_resp_unexpected", {f_if.resp_err, f_if.resp_data}, 33'h0);
        else check("f_resp", {f_if.resp_err, f_if.resp_data}, f_exp_q.pop_front());
      end
      if (d_if.resp_valid && d_if.resp_ready) begin
        if (d_exp_q.size() == 0) check("d_resp_unexpected", {d_if.resp_err, d_if.resp_data}, 33'h0);
        else check("d_resp", {d_if.resp_err, d_if.resp_data}, d_exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic fv, input logic [31:0] fa, input logic dv, input logic [31:0] da,
                     input logic frr, input logic drr, input logic eg_f, input logic eg_d,
                     input logic [32:0] ef, input logic [32:0] ed);
    @(posedge clk); #1;
    f_if.req_valid = fv; f_if.req_addr = fa; f_if.resp_ready = frr;
    d_if.req_valid = dv; d_if.req_addr = da; d_if.resp_ready = drr;
    @(negedge clk);
    check("f_req_ready", 33'(f_if.req_ready), 33'(eg_f));
    check("d_req_ready", 33'(d_if.req_ready), 33'(eg_d));
    if (eg_f) f_exp_q.push_back(ef);
    if (eg_d) d_exp_q.push_back(ed);
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 33'h0, 33'h0);
  endtask

  // Requests stay asserted through reset; none may be accepted or answered.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    f_if.req_valid = 1'b1; f_if.req_addr = 32'h4;   f_if.resp_ready = 1'b0;
    d_if.req_valid = 1'b1; d_if.req_addr = 32'h368; d_if.resp_ready = 1'b0;
    f_exp_q.delete();
    d_exp_q.delete();
    @(negedge clk);
    check("rst_f_req_ready", 33'(f_if.req_ready), 33'h0);
    check("rst_d_req_ready", 33'(d_if.req_ready), 33'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_f_resp_valid", 33'(f_if.resp_valid), 33'h0);
    check("rst_d_resp_valid", 33'(d_if.resp_valid), 33'h0);
    check("rst_last_grant", 33'(dbg_last_grant), 33'(PORT_D));
    @(posedge clk); #1;
    rst = 1'b0;
    f_if.req_valid = 1'b0; d_if.req_valid = 1'b0;
    f_if.resp_ready = 1'b1; d_if.resp_ready = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    f_if.req_valid = 1'b0; f_if.req_addr = 32'h0; f_if.resp_ready = 1'b0;
    d_if.req_valid = 1'b0; d_if.req_addr = 32'h0; d_if.resp_ready = 1'b0;
    do_reset();

    // single fetch
    cyc(1, 32'h4, 0, 32'h0, 1, 1, 1, 0, {1'b0, 32'h0800_0c05}, 33'h0);
    idle();

    // contention: last winner is F, so D goes first
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) cyc(1, 32'h0, 1, 32'h368, 1, 1, 0, 1, 33'h0, {1'b0, 32'h03e0_0008});
      else            cyc(1, 32'h0, 1, 32'h368, 1, 1, 1, 0, {1'b0, 32'h2011_0001}, 33'h0);
    end
    idle();

    // faults on D: misaligned, out of range, then a good address
    cyc(0, 32'h0, 1, 32'h6,    1, 1, 0, 1, 33'h0, {1'b1, 32'h0});
    cyc(0, 32'h0, 1, 32'h4000, 1, 1, 0, 1, 33'h0, {1'b1, 32'h0});
    cyc(0, 32'h0, 1, 32'h3ffc, 1, 1, 0, 1, 33'h0, {1'b0, 32'hdead_beef});
    cyc(0, 32'h0, 1, 32'h8,    1, 1, 0, 1, 33'h0, {1'b0, 32'h2011_0001});
    idle();

    // F response held for three cycles while D keeps flowing
    do_reset();
    cyc(1, 32'h0, 1, 32'h368, 0, 1, 1, 0, {1'b0, 32'h2011_0001}, 33'h0);
    repeat (3) cyc(1, 32'h4, 1, 32'h368, 0, 1, 0, 1, 33'h0, {1'b0, 32'h03e0_0008});
    cyc(1, 32'h4, 0, 32'h0, 1, 1, 1, 0, {1'b0, 32'h0800_0c05}, 33'h0);
    idle();
`ifdef ROM_FETCH_ARBITER_PERF_EN
    check("perf_f_stall", 33'(perf_f_stall), 33'd3);
    check("perf_d_stall", 33'(perf_d_stall), 33'd1);
`else
    check("perf_f_stall", 33'(perf_f_stall), 33'd0);
    check("perf_d_stall", 33'(perf_d_stall), 33'd0);
`endif

    // reset while a response is still undrained; first contention afterwards goes to F
    cyc(1, 32'h4, 0, 32'h0, 0, 1, 1, 0, {1'b0, 32'h0800_0c05}, 33'h0);
    do_reset();
    cyc(1, 32'h0, 1, 32'h368, 1, 1, 1, 0, {1'b0, 32'h2011_0001}, 33'h0);
    cyc(1, 32'h0, 1, 32'h368, 1, 1, 0, 1, 33'h0, {1'b0, 32'h03e0_0008});
    idle();

    // back-to-back fetches, D idle
    cyc(1, 32'h0, 0, 32'h0, 1, 1, 1, 0, {1'b0, 32'h2011_0001}, 33'h0);
    cyc(1, 32'h4, 0, 32'h0, 1, 1, 1, 0, {1'b0, 32'h0800_0c05}, 33'h0);
    cyc(1, 32'h8, 0, 32'h0, 1, 1, 1, 0, {1'b0, 32'h2011_0001}, 33'h0);
    idle();
    idle();

    check("f_queue_drained", 33'(f_exp_q.size()), 33'h0);
    check("d_queue_drained", 33'(d_exp_q.size()), 33'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_fetch_arbiter.md
Name: rom_fetch_arbiter

Overview:
Shares the single combinational instruction ROM (16 KB, word-aligned) between two requesters: port F (instruction fetch) and port D (data-side reads of the code region, e.g. lw of constant tables).
- Round-robin arbitration, one ROM lookup per cycle.
- Each port gets a registered, one-entry response slot with valid/ready handshake.
- Misaligned or out-of-range addresses are detected and return an error response instead of ROM data.

Parameters:
ROM_BYTES, 16384, size of ROM address space in bytes; valid addresses are 0 to ROM_BYTES-4.
ADDR_W, 32, request address width.
DATA_W, 32, ROM word width.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
f_req_valid  input  1  fetch request valid
f_req_addr  input  ADDR_W  fetch byte address
f_req_ready  output  1  fetch request accepted this cycle
f_resp_valid  output  1  fetch response valid
f_resp_data  output  DATA_W  fetch instruction word
f_resp_err  output  1  fetch address fault
f_resp_ready  input  1  fetch consumer accepts response
d_req_valid / d_req_addr / d_req_ready  as F, data port
d_resp_valid / d_resp_data / d_resp_err / d_resp_ready  as F, data port
rom_address  output  ADDR_W  address driven to ROM
rom_result  input  DATA_W  combinational ROM word
perf_f_stall  output  32  fetch stall counter (see optional feature)
perf_d_stall  output  32  data stall counter

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All resp_valid=0, resp_data=0, resp_err=0.
  - Round-robin pointer last_grant=D, so F wins the first contention.
  - Perf counters=0.
  - rst overrides any in-flight handshake; no response is produced for a request presented during reset.
- Slot free (per port): resp_valid=0, OR (resp_valid=1 AND resp_ready=1) in the same cycle.
- Eligible (per port): req_valid AND slot free.
- Grant:
  - One eligible port: that port is granted.
  - Both eligible: grant the port not equal to last_grant; then last_grant <= granted port.
  - last_grant is unchanged when there is no grant.
- req_ready: combinational; equals grant for that port. Never asserted while rst=1.
- rom_address: granted port's address with bits [1:0] forced to 0. When idle, rom_address holds the previous value; it is a don't-care for verification.
- Fault: addr[1:0]!=0 OR addr > ROM_BYTES-4, using unsigned compare at full ADDR_W.
- Latency: exactly 1 cycle. At the clk edge after a grant, the granted slot loads:
  - resp_valid=1;
  - resp_err=fault;
  - resp_data = fault ? 0 : rom_result.
- Holding: a slot holds data, err and valid stable until resp_ready=1.
  - Reload of a draining slot in the same cycle is allowed (back-to-back throughput 1/cycle per port when the other port is idle).
  - A slot clears to resp_valid=0 when drained without reload.
- Contention throughput: with both ports requesting continuously and always ready, grants alternate F,D,F,D...
- Response ordering: per port, responses are in request order (trivially, one outstanding per port).
- No combinational path from resp_ready to resp_valid/resp_data. The only comb path from resp_ready is to req_ready.

Optional Feature:
Macro ROM_FETCH_ARBITER_PERF_EN.
- Defined: perf_f_stall increments each cycle f_req_valid=1 AND f_req_ready=0; perf_d_stall likewise for D. Counters saturate at 0xFFFFFFFF and clear on rst.
- Undefined: both perf outputs are tied to 0 and no counter flops are synthesised.

Decomposition:
- Package rom_arb_pkg:
  - ROM_BYTES_DEFAULT=16384;
  - port index constants PORT_F=0, PORT_D=1;
  - helper function addr_fault(addr, rom_bytes).
- Sub-module rom_arb_resp_slot: one-entry valid/ready response register with load, drain and reload-while-drain. Instantiated twice (F, D); exports slot_free.
- Top module holds round-robin pointer, fault check, ROM address mux and perf counters.

Test Plan:
- Reset then single F request, addr 0x00000004, ROM word 0x08000c05 -> f_req_ready=1 same cycle; next cycle f_resp_valid=1, data=0x08000c05, err=0; d_resp_valid stays 0.
- Both ports request every cycle (F addr 0x0, D addr 0x368), both resp_ready=1 -> grants F,D,F,D. F returns 0x20110001; D returns 0x03e00008 one cycle after each D grant.
- D request addr 0x00000006, then addr 0x00004000 -> each response err=1, data=0; the next aligned request 0x00000008 returns 0x20110001, err=0.
- F response held with f_resp_ready=0 for 3 cycles while f_req_valid=1 -> f_req_ready=0 those cycles, response stable. D requests are still granted every cycle. Perf build: perf_f_stall=3.
- rst asserted one cycle after a grant, before the response is drained -> next cycle all resp_valid=0, pointer reset. The first post-reset contention grants F.
- Back-to-back F requests 0x0,0x4,0x8 with f_resp_ready=1, D idle -> three consecutive responses 0x20110001, 0x08000c05, 0x20110001 with no bubble.
